id_ex_hazard_stage: RTL
=======================

Name: id_ex_hazard_stage

Overview:
- Parametrised successor to the combinational decode stage: owns the ID/EX pipeline register plus the hazard and redirect control that decode leaves as TODO.
- Detects load-use and flag-dependency hazards, inserts bubbles and holds F/D, and issues the F/D flush on taken branches.
- Sequences processor halt through a drain FSM and keeps saturating stall/flush performance counters.
- Sits between decode (payload and register selectors in) and execute (registered payload out).

Parameters:
PAYLOAD_W, 71, width of the decode data+control bundle carried to EX
REG_AW, 4, register-number width
DRAIN_CYCLES, 3, cycles between the halt instruction entering EX and assertion of halted (min 1)
CNT_W, 16, width of each performance counter
ZERO_REG_EXEMPT, 1, when 1, register 0 never creates a load-use hazard

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  decode holds a real instruction
id_payload  in  PAYLOAD_W  decode bundle to latch into ID/EX
id_rr1  in  REG_AW  source register 1 number
id_rr2  in  REG_AW  source register 2 number
id_rr1_used  in  1  instruction reads rr1
id_rr2_used  in  1  instruction reads rr2
id_wr_reg  in  REG_AW  destination register
id_memread  in  1  instruction is a load
id_flag_en  in  1  instruction writes flags in EX
id_uses_flags  in  1  conditional branch reading flags in ID
id_branch_taken  in  1  branch resolved taken in ID (unconditional or condition met)
id_halt  in  1  instruction is HLT
ex_valid  out  1  ID/EX register holds a real instruction
ex_payload  out  PAYLOAD_W  registered bundle (zero when bubble)
stall_fd  out  1  hold PC and F/D register this cycle (combinational)
flush_fd  out  1  replace F/D contents with a bubble next edge (combinational)
halted  out  1  pipeline drained after HLT (registered)
stall_cnt  out  CNT_W  hazard-stall cycles, saturating
flush_cnt  out  CNT_W  taken-branch flushes, saturating

Behaviour:
- Internal EX shadow registers: ex_valid, ex_wr_reg, ex_memread, ex_flag_en, captured together with ex_payload.
- Reset (rst=1 at an edge): ex_valid=0, ex_payload=0, shadows=0, state=RUN, halted=0, both counters=0. Reset overrides everything, including mid-drain.
- load_use = id_valid & ex_valid & ex_memread & ((id_rr1_used & id_rr1==ex_wr_reg) | (id_rr2_used & id_rr2==ex_wr_reg)), suppressed when ZERO_REG_EXEMPT=1 and ex_wr_reg==0.
- flag_haz = id_valid & id_uses_flags & ex_valid & ex_flag_en.
- hz = (state==RUN) & (load_use | flag_haz).
- FSM states: RUN, DRAIN, HALTED.
  - RUN, hz=1: stall_fd=1, flush_fd=0. ID/EX loads a bubble (ex_valid=0, payload 0). stall_cnt increments.
  - RUN, hz=0: ID/EX loads the id_* values, with ex_valid=id_valid.
    - flush_fd = id_valid & id_branch_taken; flush_cnt increments when it is 1.
    - If id_valid & id_halt: go to DRAIN, drain counter=DRAIN_CYCLES-1, stall_fd=1 this cycle.
  - DRAIN: stall_fd=1, flush_fd=0, ID/EX loads bubbles. The counter decrements; on the cycle it reads 0, go to HALTED.
  - HALTED: stall_fd=1, ID/EX bubbles, halted=1. Absorbing until rst.
- Priority: rst > hazard stall > halt > branch flush. A stalled branch does not flush; the flush fires on its first unstalled cycle.
- Latency: id_payload appears on ex_payload one edge after a non-stalled RUN cycle.
- id_valid=0 never causes stall, flush, halt or counter change.
- Counters saturate at all-ones and do not wrap.
- Outputs stall_fd and flush_fd are combinational from current state and ID inputs. All other outputs are registered.

Test Plan:
- Reset: rst=1 for 2 cycles with random id_* inputs -> ex_valid=0, ex_payload=0, halted=0, counters=0, stall_fd=0 when id_valid=0.
- Load-use: EX holds a load to R3, ID reads rr2=R3 with id_rr2_used=1 -> stall_fd=1 for exactly one cycle, bubble in EX, stall_cnt=1. Next cycle the dependent instruction enters EX. Repeat with R0 -> no stall.
- Flag hazard: EX holds ADD with flag_en=1, ID holds a conditional branch with id_branch_taken=1 -> one stall cycle, then flush_fd=1 for one cycle, flush_cnt=1.
- Taken branch without hazard: id_branch_taken=1 -> flush_fd=1 same cycle, branch payload appears in EX next edge with ex_valid=1.
- Halt with DRAIN_CYCLES=3: HLT enters EX -> stall_fd held from the HLT cycle, halted=1 exactly 3 cycles after the HLT edge and stays 1. Asserting rst during DRAIN -> RUN, halted=0.
- Saturation with CNT_W=4: 20 consecutive load-use stalls -> stall_cnt reaches 15 and holds.

Source files
------------

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use / flag hazard stalls, taken-branch flush,
// halt drain sequencing and saturating stall/flush counters.
module id_ex_hazard_stage #(
    parameter int PAYLOAD_W       = 71,
    parameter int REG_AW          = 4,
    parameter int DRAIN_CYCLES    = 3,
    parameter int CNT_W           = 16,
    parameter int ZERO_REG_EXEMPT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [PAYLOAD_W-1:0] id_payload,
    input  logic [REG_AW-1:0]    id_rr1,
    input  logic [REG_AW-1:0]    id_rr2,
    input  logic                 id_rr1_used,
    input  logic                 id_rr2_used,
    input  logic [REG_AW-1:0]    id_wr_reg,
    input  logic                 id_memread,
    input  logic                 id_flag_en,
    input  logic                 id_uses_flags,
    input  logic                 id_branch_taken,
    input  logic                 id_halt,
    output logic                 ex_valid,
    output logic [PAYLOAD_W-1:0] ex_payload,
    output logic                 stall_fd,
    output logic                 flush_fd,
    output logic                 halted,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [DCW-1:0]       drain_q, drain_d;
    logic                 ex_valid_q, ex_valid_d;
    logic [PAYLOAD_W-1:0] ex_payload_q, ex_payload_d;
    logic [REG_AW-1:0]    ex_wr_reg_q, ex_wr_reg_d;
    logic                 ex_memread_q, ex_memread_d;
    logic                 ex_flag_en_q, ex_flag_en_d;
    logic                 halted_q, halted_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;

    logic                 reg_hit_s;
    logic                 zero_exempt_s;
    logic                 load_use_s;
    logic                 flag_haz_s;
    logic                 hz_s;
    logic                 stall_inc_s;
    logic                 flush_inc_s;
    logic                 stall_fd_s;
    logic                 flush_fd_s;

    // Hazard detection against the instruction currently held in EX.
    always_comb begin
        reg_hit_s     = (id_rr1_used & (id_rr1 == ex_wr_reg_q)) |
                        (id_rr2_used & (id_rr2 == ex_wr_reg_q));
        zero_exempt_s = (ZERO_REG_EXEMPT != 0) && (ex_wr_reg_q == {REG_AW{1'b0}});
        load_use_s    = id_valid & ex_valid_q & ex_memread_q & reg_hit_s & ~zero_exempt_s;
        flag_haz_s    = id_valid & id_uses_flags & ex_valid_q & ex_flag_en_q;
        hz_s          = (state_q == ST_RUN) & (load_use_s | flag_haz_s);
    end

    // Next-state, ID/EX load selection and F/D control.
    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        ex_valid_d   = 1'b0;
        ex_payload_d = {PAYLOAD_W{1'b0}};
        ex_wr_reg_d  = {REG_AW{1'b0}};
        ex_memread_d = 1'b0;
        ex_flag_en_d = 1'b0;
        stall_fd_s   = 1'b0;
        flush_fd_s   = 1'b0;
        stall_inc_s  = 1'b0;
        flush_inc_s  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (hz_s) begin
                    stall_fd_s  = 1'b1;
                    stall_inc_s = 1'b1;
                end else begin
                    // Invalid decode slots enter EX as clean zero bubbles.
                    ex_valid_d   = id_valid;
                    ex_payload_d = id_valid ? id_payload : {PAYLOAD_W{1'b0}};
                    ex_wr_reg_d  = id_valid ? id_wr_reg : {REG_AW{1'b0}};
                    ex_memread_d = id_valid & id_memread;
                    ex_flag_en_d = id_valid & id_flag_en;
                    if (id_valid && id_halt) begin
                        state_d    = ST_DRAIN;
                        drain_d    = DCW'(DRAIN_CYCLES - 1);
                        stall_fd_s = 1'b1;
                    end else begin
                        flush_fd_s  = id_valid & id_branch_taken;
                        flush_inc_s = id_valid & id_branch_taken;
                    end
                end
            end
            ST_DRAIN: begin
                stall_fd_s = 1'b1;
                if (drain_q == {DCW{1'b0}}) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_d = drain_q - DCW'(1);
                end
            end
            ST_HALTED: begin
                stall_fd_s = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        halted_d    = (state_d == ST_HALTED);
        stall_cnt_d = (stall_inc_s && (stall_cnt_q != {CNT_W{1'b1}})) ?
                      stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (flush_inc_s && (flush_cnt_q != {CNT_W{1'b1}})) ?
                      flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    // State, ID/EX register and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            drain_q      <= {DCW{1'b0}};
            ex_valid_q   <= 1'b0;
            ex_payload_q <= {PAYLOAD_W{1'b0}};
            ex_wr_reg_q  <= {REG_AW{1'b0}};
            ex_memread_q <= 1'b0;
            ex_flag_en_q <= 1'b0;
            halted_q     <= 1'b0;
            stall_cnt_q  <= {CNT_W{1'b0}};
            flush_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            drain_q      <= drain_d;
            ex_valid_q   <= ex_valid_d;
            ex_payload_q <= ex_payload_d;
            ex_wr_reg_q  <= ex_wr_reg_d;
            ex_memread_q <= ex_memread_d;
            ex_flag_en_q <= ex_flag_en_d;
            halted_q     <= halted_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_payload = ex_payload_q;
    assign halted     = halted_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign stall_fd   = stall_fd_s;
    assign flush_fd   = flush_fd_s;

endmodule
